reorder_buffer_mc: RTL and testbench
====================================

REORDER_BUFFER_MC -- requirements
Module: reorder_buffer_mc

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16: entry count, power of two, 4..64.
REQ-002 SHALL have parameter WB_PORTS, default 2: number of writeback ports (ALU, LSB, ...), 1..4.
REQ-003 SHALL have parameter COMMIT_WIDTH, default 2: maximum retirements per cycle, 1 or 2.
REQ-004 SHALL have local constant IDX_W = log2(ROB_DEPTH).
REQ-005 clk_in  input  1  single clock; all state on its rising edge.
REQ-006 rst_in  input  1  reset, synchronous, active-high.
REQ-007 rdy_in  input  1  global enable; low = stall.
REQ-008 iss_valid  input  1  decoder presents an instruction.
REQ-009 iss_op  input  OP_W  opcode class (OP_BR, OP_JALR, other).
REQ-010 iss_rd  input  5  destination register.
REQ-011 iss_pc  input  32  instruction PC.
REQ-012 iss_pred_br  input  1  predicted taken.
REQ-013 iss_idx  output  IDX_W  index the issued entry receives (= tail).
REQ-014 rob_full  output  1  no free entry.
REQ-015 wb_valid  input  WB_PORTS  per-port result valid.
REQ-016 wb_idx  input  WB_PORTS*IDX_W  per-port target entry.
REQ-017 wb_data  input  WB_PORTS*32  per-port result.
REQ-018 wb_taken  input  WB_PORTS  per-port actual branch outcome.
REQ-019 wb_target  input  WB_PORTS*32  per-port resolved target.
REQ-020 op_idx  input  2*IDX_W  rs1/rs2 rename lookup indices.
REQ-021 op_ready  output  2  looked-up entry has a result.
REQ-022 op_val  output  64  looked-up results {rs2,rs1}.
REQ-023 head_idx  output  IDX_W  oldest entry (LSB store release).
REQ-024 head_valid  output  1  buffer non-empty.
REQ-025 cmt_valid  output  COMMIT_WIDTH  per-slot retire pulse.
REQ-026 cmt_rd / cmt_idx / cmt_val  output  COMMIT_WIDTH*(5 / IDX_W / 32)  per-slot rd, entry index, value.
REQ-027 flush  output  1  mispredict pulse; clears the pipeline.
REQ-028 flush_pc  output  32  fetch redirect PC.
REQ-029 bp_upd_valid / bp_upd_pc / bp_upd_taken  output  1/32/1  predictor training for retired OP_BR.

Function
REQ-030 SHALL keep head, tail (wrap modulo ROB_DEPTH, no reserved slot) and occupancy count 0..ROB_DEPTH; rob_full = (count == ROB_DEPTH).
REQ-031 SHALL accept issue when iss_valid && !rob_full && rdy_in && !flush: entry at tail cleared (ready=0, taken=0, target=0), tail+1; issue into a full buffer is dropped, with no state change.
REQ-032 SHALL mark an entry ready on wb_valid, storing data, taken and target; same-index multi-port collision: highest port number wins.
REQ-033 Slot 0 SHALL retire head when count>0 and head is ready.
REQ-034 Slot 1 (COMMIT_WIDTH=2) SHALL retire head+1 only if slot 0 retires, count>=2, head+1 is ready, and slot 0 is neither OP_BR nor OP_JALR.
REQ-035 Commit outputs SHALL be registered: cmt_* valid one cycle after the retiring edge; head and count update by the number retired, net of issue in the same cycle.
REQ-036 Mispredict (retiring pred != taken) SHALL register flush=1 with flush_pc = pred ? pc+4 : target.
REQ-037 Retired OP_BR SHALL pulse bp_upd_* for one cycle, regardless of mispredict.
REQ-038 While flush=1: head=tail=count=0, all pulse outputs 0, issue/writeback ignored; flush self-clears after one cycle.
REQ-039 rdy_in=0 SHALL freeze head/tail/count/entries and drive all pulse outputs 0.
REQ-040 op_ready/op_val SHALL be combinational reads of the entry's ready flag and result.

Reset
REQ-041 rst_in SHALL clear head, tail, count, flush, cmt_valid and bp_upd_valid; other outputs reset to 0; entry payloads are not reset.
REQ-042 rst_in SHALL take priority over flush and rdy_in and SHALL abort any in-flight commit.

Configuration
REQ-043 With ROB_WB_BYPASS_EN defined, op_ready/op_val SHALL also forward same-cycle wb_* matching op_idx, highest port winning; without it, the lookup sees registered state only (one-cycle-later visibility).

Structure
REQ-044 OP_W, OP_BR/OP_JALR codes and index-width function SHALL live in the shared def package.
REQ-045 Commit-slot selection SHALL be sub-module rob_commit_sel (combinational, per-slot eligibility).

Verification (ROB_DEPTH=8, WB_PORTS=2, COMMIT_WIDTH=2)
REQ-046 Issue 8 without writeback -> rob_full=1 after the 8th; 9th dropped; iss_idx sequence 0..7.
REQ-047 Write back entries 0,1 (ALU data 5, LSB data 9) in the same cycle -> next cycle cmt_valid=2'b11, cmt_val={9,5}.
REQ-048 OP_BR at head, pred=1, taken=0, pc=0x100 -> flush=1, flush_pc=0x104, bp_upd_taken=0; entry behind it not retired; count=0 after.
REQ-049 Head at 7, issue two -> tail wraps to 1; retire all -> head=1, count=0.
REQ-050 rdy_in=0 for 3 cycles with ready head -> no cmt_valid; resumes retire on rdy_in=1; rst_in mid-stream -> count=0, no further commits.

Source files
------------

// File: rtl/reorder_buffer_mc_pkg.sv
// Shared definitions for the reorder buffer: opcode classes and the
// index-width helper.
package reorder_buffer_mc_pkg;

    localparam int unsigned OP_W = 2;

    localparam logic [OP_W-1:0] OP_OTHER = 2'd0;
    localparam logic [OP_W-1:0] OP_BR    = 2'd1;
    localparam logic [OP_W-1:0] OP_JALR  = 2'd2;

    typedef enum logic [OP_W-1:0] {
        OpOther = 2'd0,
        OpBr    = 2'd1,
        OpJalr  = 2'd2
    } rob_op_e;

    // Bits needed to index a buffer of the given (power-of-two) depth.
    function automatic int unsigned rob_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Control-flow ops end a commit group: nothing younger retires with them.
    function automatic logic rob_is_ctrl(input logic [OP_W-1:0] op);
        return (op == OP_BR) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Commit-slot selection for the reorder buffer (purely combinational).
// Ports:
//   en_i      - retirement allowed this cycle (enabled and not flushing)
//   count_i   - current occupancy
//   ready_i   - ready flag of head+s for each slot s
//   op_i      - opcode class of head+s for each slot s
//   retire_o  - slot s retires this cycle
// Slot s retires only if every older slot retires, enough entries exist, its
// entry is ready and the next-older slot is not a branch or jump.
module rob_commit_sel
    import reorder_buffer_mc_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned CNT_W        = 5
) (
    input  logic                         en_i,
    input  logic [CNT_W-1:0]             count_i,
    input  logic [COMMIT_WIDTH-1:0]      ready_i,
    input  logic [COMMIT_WIDTH*OP_W-1:0] op_i,
    output logic [COMMIT_WIDTH-1:0]      retire_o
);

    always_comb begin
        retire_o    = '0;
        retire_o[0] = en_i && (count_i != '0) && ready_i[0];
        for (int s = 1; s < COMMIT_WIDTH; s++) begin
            retire_o[s] = retire_o[s-1] && (count_i > CNT_W'(s)) && ready_i[s] &&
                          !rob_is_ctrl(op_i[(s-1)*OP_W +: OP_W]);
        end
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Reorder buffer with multi-port writeback and up to two retirements per cycle.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   iss_*   - issue from decode; iss_idx returns the allocated entry, rob_full
//   wb_*    - per-port writeback (result, branch outcome, resolved target)
//   op_idx  - rs1/rs2 rename lookups -> op_ready / op_val {rs2,rs1}
//   head_idx/head_valid - oldest entry
//   cmt_*   - registered per-slot retirement
//   flush/flush_pc      - registered mispredict redirect
//   bp_upd_* - predictor training for retired OP_BR
// Optional: define ROB_WB_BYPASS_EN to forward same-cycle writebacks to the
// operand lookup.
module reorder_buffer_mc
    import reorder_buffer_mc_pkg::*;
#(
    parameter int unsigned ROB_DEPTH    = 16,
    parameter int unsigned WB_PORTS     = 2,
    parameter int unsigned COMMIT_WIDTH = 2,
    localparam int unsigned IDX_W       = rob_idx_w(ROB_DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         iss_valid,
    input  logic [OP_W-1:0]              iss_op,
    input  logic [4:0]                   iss_rd,
    input  logic [31:0]                  iss_pc,
    input  logic                         iss_pred_br,
    output logic [IDX_W-1:0]             iss_idx,
    output logic                         rob_full,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
    input  logic [WB_PORTS*32-1:0]       wb_data,
    input  logic [WB_PORTS-1:0]          wb_taken,
    input  logic [WB_PORTS*32-1:0]       wb_target,
    input  logic [2*IDX_W-1:0]           op_idx,
    output logic [1:0]                   op_ready,
    output logic [63:0]                  op_val,
    output logic [IDX_W-1:0]             head_idx,
    output logic                         head_valid,
    output logic [COMMIT_WIDTH-1:0]      cmt_valid,
    output logic [COMMIT_WIDTH*5-1:0]    cmt_rd,
    output logic [COMMIT_WIDTH*IDX_W-1:0] cmt_idx,
    output logic [COMMIT_WIDTH*32-1:0]   cmt_val,
    output logic                         flush,
    output logic [31:0]                  flush_pc,
    output logic                         bp_upd_valid,
    output logic [31:0]                  bp_upd_pc,
    output logic                         bp_upd_taken
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flush_q, flush_d;
    logic [31:0]      flush_pc_q, flush_pc_d;
    logic [COMMIT_WIDTH-1:0]       cmt_valid_q, cmt_valid_d;
    logic [COMMIT_WIDTH*5-1:0]     cmt_rd_q, cmt_rd_d;
    logic [COMMIT_WIDTH*IDX_W-1:0] cmt_idx_q, cmt_idx_d;
    logic [COMMIT_WIDTH*32-1:0]    cmt_val_q, cmt_val_d;
    logic             bp_valid_q, bp_valid_d, bp_taken_q, bp_taken_d;
    logic [31:0]      bp_pc_q, bp_pc_d;

    logic [ROB_DEPTH-1:0] ent_ready_q, ent_ready_d;
    logic [ROB_DEPTH-1:0] ent_taken_q, ent_taken_d;
    logic [ROB_DEPTH-1:0] ent_pred_q, ent_pred_d;
    logic [OP_W-1:0]      ent_op_q [ROB_DEPTH];
    logic [OP_W-1:0]      ent_op_d [ROB_DEPTH];
    logic [4:0]           ent_rd_q [ROB_DEPTH];
    logic [4:0]           ent_rd_d [ROB_DEPTH];
    logic [31:0]          ent_pc_q [ROB_DEPTH];
    logic [31:0]          ent_pc_d [ROB_DEPTH];
    logic [31:0]          ent_data_q [ROB_DEPTH];
    logic [31:0]          ent_data_d [ROB_DEPTH];
    logic [31:0]          ent_tgt_q [ROB_DEPTH];
    logic [31:0]          ent_tgt_d [ROB_DEPTH];

    logic                         run, iss_fire;
    logic [IDX_W-1:0]             slot_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]      slot_ready, retire;
    logic [COMMIT_WIDTH*OP_W-1:0] slot_op;
    logic [CNT_W-1:0]             n_ret;

    assign run      = rdy_in && !flush_q;
    assign rob_full = (count_q == CNT_W'(ROB_DEPTH));
    assign iss_fire = iss_valid && !rob_full && run;

    always_comb begin
        slot_ready = '0;
        slot_op    = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            slot_idx[s]                 = head_q + IDX_W'(s);
            slot_ready[s]               = ent_ready_q[slot_idx[s]];
            slot_op[s*OP_W +: OP_W]     = ent_op_q[slot_idx[s]];
        end
    end

    rob_commit_sel #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .CNT_W        (CNT_W)
    ) u_commit_sel (
        .en_i     (run),
        .count_i  (count_q),
        .ready_i  (slot_ready),
        .op_i     (slot_op),
        .retire_o (retire)
    );

    // Entry updates: writeback in ascending port order so the highest port
    // wins a collision; a fresh issue then reinitialises the tail entry.
    always_comb begin
        ent_ready_d = ent_ready_q;
        ent_taken_d = ent_taken_q;
        ent_pred_d  = ent_pred_q;
        ent_op_d    = ent_op_q;
        ent_rd_d    = ent_rd_q;
        ent_pc_d    = ent_pc_q;
        ent_data_d  = ent_data_q;
        ent_tgt_d   = ent_tgt_q;
        if (run) begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p]) begin
                    ent_ready_d[wb_idx[p*IDX_W +: IDX_W]] = 1'b1;
                    ent_taken_d[wb_idx[p*IDX_W +: IDX_W]] = wb_taken[p];
                    ent_data_d[wb_idx[p*IDX_W +: IDX_W]]  = wb_data[p*32 +: 32];
                    ent_tgt_d[wb_idx[p*IDX_W +: IDX_W]]   = wb_target[p*32 +: 32];
                end
            end
        end
        if (iss_fire) begin
            ent_ready_d[tail_q] = 1'b0;
            ent_taken_d[tail_q] = 1'b0;
            ent_tgt_d[tail_q]   = '0;
            ent_pred_d[tail_q]  = iss_pred_br;
            ent_op_d[tail_q]    = iss_op;
            ent_rd_d[tail_q]    = iss_rd;
            ent_pc_d[tail_q]    = iss_pc;
        end
    end

    // Retirement outputs; only one control op can retire per cycle, so at
    // most one slot can raise flush or train the predictor.
    always_comb begin
        cmt_valid_d = '0;
        cmt_rd_d    = cmt_rd_q;
        cmt_idx_d   = cmt_idx_q;
        cmt_val_d   = cmt_val_q;
        flush_d     = 1'b0;
        flush_pc_d  = flush_pc_q;
        bp_valid_d  = 1'b0;
        bp_pc_d     = bp_pc_q;
        bp_taken_d  = bp_taken_q;
        n_ret       = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            if (retire[s]) begin
                n_ret                        = n_ret + CNT_W'(1);
                cmt_valid_d[s]               = 1'b1;
                cmt_rd_d[s*5 +: 5]           = ent_rd_q[slot_idx[s]];
                cmt_idx_d[s*IDX_W +: IDX_W]  = slot_idx[s];
                cmt_val_d[s*32 +: 32]        = ent_data_q[slot_idx[s]];
                if (rob_is_ctrl(ent_op_q[slot_idx[s]]) &&
                    (ent_pred_q[slot_idx[s]] != ent_taken_q[slot_idx[s]])) begin
                    flush_d    = 1'b1;
                    flush_pc_d = ent_pred_q[slot_idx[s]] ? ent_pc_q[slot_idx[s]] + 32'd4
                                                         : ent_tgt_q[slot_idx[s]];
                end
                if (ent_op_q[slot_idx[s]] == OP_BR) begin
                    bp_valid_d = 1'b1;
                    bp_pc_d    = ent_pc_q[slot_idx[s]];
                    bp_taken_d = ent_taken_q[slot_idx[s]];
                end
            end
        end
    end

    // A mispredict empties the buffer on the same edge that raises flush.
    always_comb begin
        if (flush_q || flush_d) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + IDX_W'(n_ret);
            tail_d  = tail_q + IDX_W'(iss_fire);
            count_d = count_q + CNT_W'(iss_fire) - n_ret;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            flush_q     <= 1'b0;
            flush_pc_q  <= '0;
            cmt_valid_q <= '0;
            cmt_rd_q    <= '0;
            cmt_idx_q   <= '0;
            cmt_val_q   <= '0;
            bp_valid_q  <= 1'b0;
            bp_pc_q     <= '0;
            bp_taken_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            flush_q     <= flush_d;
            flush_pc_q  <= flush_pc_d;
            cmt_valid_q <= cmt_valid_d;
            cmt_rd_q    <= cmt_rd_d;
            cmt_idx_q   <= cmt_idx_d;
            cmt_val_q   <= cmt_val_d;
            bp_valid_q  <= bp_valid_d;
            bp_pc_q     <= bp_pc_d;
            bp_taken_q  <= bp_taken_d;
        end
    end

    // Entry payloads carry no reset; issue reinitialises what matters.
    always_ff @(posedge clk_in) begin
        ent_ready_q <= ent_ready_d;
        ent_taken_q <= ent_taken_d;
        ent_pred_q  <= ent_pred_d;
        ent_op_q    <= ent_op_d;
        ent_rd_q    <= ent_rd_d;
        ent_pc_q    <= ent_pc_d;
        ent_data_q  <= ent_data_d;
        ent_tgt_q   <= ent_tgt_d;
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            op_ready[k]          = ent_ready_q[op_idx[k*IDX_W +: IDX_W]];
            op_val[k*32 +: 32]   = ent_data_q[op_idx[k*IDX_W +: IDX_W]];
`ifdef ROB_WB_BYPASS_EN
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && (wb_idx[p*IDX_W +: IDX_W] == op_idx[k*IDX_W +: IDX_W])) begin
                    op_ready[k]        = 1'b1;
                    op_val[k*32 +: 32] = wb_data[p*32 +: 32];
                end
            end
`endif
        end
    end

    assign iss_idx      = tail_q;
    assign head_idx     = head_q;
    assign head_valid   = (count_q != '0);
    assign cmt_valid    = cmt_valid_q;
    assign cmt_rd       = cmt_rd_q;
    assign cmt_idx      = cmt_idx_q;
    assign cmt_val      = cmt_val_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;
    assign bp_upd_valid = bp_valid_q;
    assign bp_upd_pc    = bp_pc_q;
    assign bp_upd_taken = bp_taken_q;

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc (depth 8, two writeback ports, two
// commit slots). Expected commits are queued at issue and popped as the
// buffer retires them.
module tb_reorder_buffer_mc;
    import reorder_buffer_mc_pkg::*;

    logic        clk_in, rst_in, rdy_in;
    logic        iss_valid;
    logic [1:0]  iss_op;
    logic [4:0]  iss_rd;
    logic [31:0] iss_pc;
    logic        iss_pred_br;
    logic [2:0]  iss_idx;
    logic        rob_full;
    logic [1:0]  wb_valid;
    logic [5:0]  wb_idx;
    logic [63:0] wb_data;
    logic [1:0]  wb_taken;
    logic [63:0] wb_target;
    logic [5:0]  op_idx;
    logic [1:0]  op_ready;
    logic [63:0] op_val;
    logic [2:0]  head_idx;
    logic        head_valid;
    logic [1:0]  cmt_valid;
    logic [9:0]  cmt_rd;
    logic [5:0]  cmt_idx;
    logic [63:0] cmt_val;
    logic        flush;
    logic [31:0] flush_pc;
    logic        bp_upd_valid;
    logic [31:0] bp_upd_pc;
    logic        bp_upd_taken;

    int total = 0;
    int bad   = 0;
    logic [39:0] sb[$];
    logic [2:0]  exp_tail;

    reorder_buffer_mc #(
        .ROB_DEPTH    (8),
        .WB_PORTS     (2),
        .COMMIT_WIDTH (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .iss_valid    (iss_valid),
        .iss_op       (iss_op),
        .iss_rd       (iss_rd),
        .iss_pc       (iss_pc),
        .iss_pred_br  (iss_pred_br),
        .iss_idx      (iss_idx),
        .rob_full     (rob_full),
        .wb_valid     (wb_valid),
        .wb_idx       (wb_idx),
        .wb_data      (wb_data),
        .wb_taken     (wb_taken),
        .wb_target    (wb_target),
        .op_idx       (op_idx),
        .op_ready     (op_ready),
        .op_val       (op_val),
        .head_idx     (head_idx),
        .head_valid   (head_valid),
        .cmt_valid    (cmt_valid),
        .cmt_rd       (cmt_rd),
        .cmt_idx      (cmt_idx),
        .cmt_val      (cmt_val),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .bp_upd_valid (bp_upd_valid),
        .bp_upd_pc    (bp_upd_pc),
        .bp_upd_taken (bp_upd_taken)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, and score any commits.
    task automatic tick();
        logic [39:0] e;
        @(posedge clk_in);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (cmt_valid[s] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("cmt_spurious", 64'(cmt_valid[s]), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("cmt_slot", 64'({cmt_rd[s*5 +: 5], cmt_idx[s*3 +: 3], cmt_val[s*32 +: 32]}),
                        64'(e));
                end
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pred, input logic [31:0] val, input bit expect_commit);
        chk("iss_idx", 64'(iss_idx), 64'(exp_tail));
        iss_valid   = 1'b1;
        iss_op      = op;
        iss_rd      = rd;
        iss_pc      = pc;
        iss_pred_br = pred;
        tick();
        iss_valid = 1'b0;
        if (expect_commit) sb.push_back({rd, exp_tail, val});
        exp_tail = exp_tail + 3'd1;
    endtask

    task automatic wbp(input logic [1:0] v, input logic [2:0] i0, input logic [31:0] d0,
                       input logic [2:0] i1, input logic [31:0] d1, input logic t1,
                       input logic [31:0] tg1);
        wb_valid  = v;
        wb_idx    = {i1, i0};
        wb_data   = {d1, d0};
        wb_taken  = {t1, 1'b0};
        wb_target = {tg1, 32'd0};
        tick();
        wb_valid = 2'b00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        iss_valid = 1'b0; iss_op = OP_OTHER; iss_rd = '0; iss_pc = '0; iss_pred_br = 1'b0;
        wb_valid = '0; wb_idx = '0; wb_data = '0; wb_taken = '0; wb_target = '0;
        op_idx = {3'd1, 3'd0};
        exp_tail = 3'd0;
        idle(2);
        rst_in = 1'b0;
        chk("rst_head_valid", 64'(head_valid), 64'd0);
        chk("rst_full", 64'(rob_full), 64'd0);
        chk("rst_cmt_valid", 64'(cmt_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_bp_valid", 64'(bp_upd_valid), 64'd0);
        chk("rst_head_idx", 64'(head_idx), 64'd0);

        // Fill the buffer; the ninth issue must be dropped.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = (i == 0) ? 32'd5 : (i == 1) ? 32'd9 : (i == 2) ? 32'd222 : 32'(100 + i);
            chk("full_early", 64'(rob_full), 64'd0);
            issue(OP_OTHER, 5'(i + 1), 32'(32'h1000 + 4 * i), 1'b0, v, 1'b1);
        end
        chk("full_after8", 64'(rob_full), 64'd1);
        iss_valid = 1'b1; iss_rd = 5'd31;
        chk("iss_idx_full", 64'(iss_idx), 64'd0);
        tick();
        iss_valid = 1'b0;
        chk("full_after9", 64'(rob_full), 64'd1);
        chk("head_after9", 64'(head_idx), 64'd0);

        // Same-cycle writeback of entries 0 and 1 on both ports.
        wb_valid = 2'b11; wb_idx = {3'd1, 3'd0}; wb_data = {32'd9, 32'd5};
        wb_taken = '0; wb_target = '0;
        chk("op_ready_unbypassed", 64'(op_ready), 64'd0);
        tick();
        wb_valid = 2'b00;
        chk("op_ready_after_wb", 64'(op_ready), 64'd3);
        chk("op_val_after_wb", op_val, {32'd9, 32'd5});
        tick();
        chk("dual_cmt_valid", 64'(cmt_valid), 64'd3);
        chk("dual_cmt_val", cmt_val, {32'd9, 32'd5});

        // Port collision on entry 2: port 1 must win.
        wbp(2'b11, 3'd2, 32'd111, 3'd2, 32'd222, 1'b0, 32'd0);
        for (int i = 3; i < 8; i++) wbp(2'b01, 3'(i), 32'(100 + i), 3'd0, 32'd0, 1'b0, 32'd0);
        idle(4);
        chk("drain1_head_valid", 64'(head_valid), 64'd0);
        chk("drain1_head_idx", 64'(head_idx), 64'd0);
        chk("drain1_full", 64'(rob_full), 64'd0);

        // Walk head to 7, then issue two so the tail wraps.
        for (int i = 0; i < 7; i++) issue(OP_OTHER, 5'(10 + i), 32'h2000, 1'b0, 32'(300 + i), 1'b1);
        for (int i = 0; i < 7; i++) wbp(2'b01, 3'(i), 32'(300 + i), 3'd0, 32'd0, 1'b0, 32'd0);
        idle(4);
        chk("head_at7", 64'(head_idx), 64'd7);
        issue(OP_OTHER, 5'd20, 32'h3000, 1'b0, 32'd77, 1'b1);
        issue(OP_OTHER, 5'd21, 32'h3004, 1'b0, 32'd88, 1'b1);
        chk("tail_wrapped", 64'(iss_idx), 64'd1);
        wbp(2'b11, 3'd7, 32'd77, 3'd0, 32'd88, 1'b0, 32'd0);
        tick();
        chk("wrap_cmt_valid", 64'(cmt_valid), 64'd3);
        chk("wrap_cmt_idx", 64'(cmt_idx), 64'({3'd0, 3'd7}));
        idle(2);
        chk("wrap_head_idx", 64'(head_idx), 64'd1);
        chk("wrap_head_valid", 64'(head_valid), 64'd0);

        // Mispredicted branch at head: predicted taken, actually not taken.
        issue(OP_BR, 5'd3, 32'h100, 1'b1, 32'hAA, 1'b1);
        issue(OP_OTHER, 5'd4, 32'h104, 1'b0, 32'h55, 1'b0);
        wbp(2'b01, 3'd2, 32'h55, 3'd0, 32'd0, 1'b0, 32'd0);
        chk("br_not_ready_cmt", 64'(cmt_valid), 64'd0);
        wbp(2'b10, 3'd0, 32'd0, 3'd1, 32'hAA, 1'b0, 32'h200);
        tick();
        chk("br_flush", 64'(flush), 64'd1);
        chk("br_flush_pc", 64'(flush_pc), 64'h104);
        chk("br_bp_valid", 64'(bp_upd_valid), 64'd1);
        chk("br_bp_taken", 64'(bp_upd_taken), 64'd0);
        chk("br_bp_pc", 64'(bp_upd_pc), 64'h100);
        chk("br_cmt_valid", 64'(cmt_valid), 64'd1);
        chk("br_count0", 64'(head_valid), 64'd0);
        tick();
        exp_tail = 3'd0;
        chk("br_flush_clear", 64'(flush), 64'd0);
        chk("br_bp_clear", 64'(bp_upd_valid), 64'd0);
        chk("br_head_idx", 64'(head_idx), 64'd0);
        chk("br_iss_idx", 64'(iss_idx), 64'd0);

        // Stall with a ready head, then resume.
        issue(OP_OTHER, 5'd5, 32'h4000, 1'b0, 32'h11, 1'b1);
        issue(OP_OTHER, 5'd6, 32'h4004, 1'b0, 32'h22, 1'b1);
        wbp(2'b11, 3'd0, 32'h11, 3'd1, 32'h22, 1'b0, 32'd0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_cmt_valid", 64'(cmt_valid), 64'd0);
        end
        chk("stall_head_valid", 64'(head_valid), 64'd1);
        rdy_in = 1'b1;
        tick();
        chk("resume_cmt_valid", 64'(cmt_valid), 64'd3);

        // Reset while a commit is about to happen.
        issue(OP_OTHER, 5'd7, 32'h5000, 1'b0, 32'h33, 1'b0);
        issue(OP_OTHER, 5'd8, 32'h5004, 1'b0, 32'h44, 1'b0);
        wbp(2'b11, 3'd2, 32'h33, 3'd3, 32'h44, 1'b0, 32'd0);
        rst_in = 1'b1;
        tick();
        chk("midrst_cmt_valid", 64'(cmt_valid), 64'd0);
        chk("midrst_head_valid", 64'(head_valid), 64'd0);
        chk("midrst_flush", 64'(flush), 64'd0);
        rst_in = 1'b0;
        exp_tail = 3'd0;
        chk("midrst_iss_idx", 64'(iss_idx), 64'd0);
        idle(3);
        chk("post_rst_head_valid", 64'(head_valid), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
